serial_tx: RTL
==============

// Module: serial_tx
// PURPOSE
//  Parallel-in, serial-out frame transmitter built from D-type registers.
//  Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out on SDO.
//  Frame order: start bit (0), data LSB-first, stop bit (1); SDO idles high.
//  Acts as the driving end of a single-wire serial link. The receiving end
//  samples SDO on rising CLK edges at the same bit period.
// PARAMETERS
//  WIDTH         8   data bits per frame (>=1)
//  CLKS_PER_BIT  1   CLK cycles each bit is held on SDO (>=1)
// PORTS
//  CLK      in   1      clock; all state changes on rising edge
//  n_Reset  in   1      synchronous, active-low reset (sampled on rising CLK only)
//  DATA     in   WIDTH  word to send; sampled only on the accepting edge
//  valid    in   1      DATA is offered
//  ready    out  1      transmitter can accept a word this cycle
//  SDO      out  1      serial data out, registered
//  busy     out  1      frame in progress (START/DATA/STOP)
//  done     out  1      one-cycle pulse after stop bit completes
// BEHAVIOUR
//  Reset: when n_Reset=0 at a rising edge, the following apply:
//   - state=IDLE, SDO=1, busy=0, done=0, ready=0, shift reg=0, counters=0.
//   - ready is held 0 while n_Reset=0; it rises the cycle after reset is released.
//   - Reset has no asynchronous path; the outputs hold until the next edge.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: SDO=1, ready=1, busy=0.
//     - The edge with valid&ready accepts the word: shift reg<=DATA, SDO<=0,
//       state<=START, ready<=0, busy<=1.
//   - START: SDO=0 for CLKS_PER_BIT cycles, counted from the accepting edge.
//     - Then SDO<=DATA[0] and state<=DATA.
//   - DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right
//     and the bit index increments. Bits go out in order DATA[0]..DATA[WIDTH-1].
//     - After the last bit, SDO<=1 and state<=STOP.
//   - STOP: SDO=1 for CLKS_PER_BIT cycles.
//     - Then state<=IDLE, busy<=0, ready<=1, done<=1 for exactly one cycle.
//  Timing:
//   - Bit counter width is $clog2(WIDTH+1); divider width is $clog2(CLKS_PER_BIT+1).
//   - The divider reloads on every bit boundary.
//   - Frame length is (WIDTH+2)*CLKS_PER_BIT cycles from the accepting edge to
//     the IDLE entry.
//   - Back-to-back: the earliest next accept is the edge at which done=1 (first
//     IDLE cycle). The minimum accept-to-accept spacing is (WIDTH+2)*CLKS_PER_BIT+1.
//  Boundary conditions:
//   - valid while busy: ignored, no queuing. DATA changes while busy: no effect.
//   - valid held high continuously: a new frame starts in each IDLE cycle
//     (one word per frame).
//   - valid=1 while n_Reset=0: not accepted; reset wins.
//   - Reset mid-frame: the frame is abandoned and SDO=1 from that edge.
//     No done pulse; the partial word is lost.
//   - CLKS_PER_BIT=1: every state lasts exactly one cycle. The divider is never
//     nonzero and no zero-length states occur.
//   - WIDTH=1: DATA state lasts one bit period.
// TESTING  (drive inputs on falling edge, check on rising edge + #1)
//  1. Reset: hold n_Reset=0 for 2 edges with valid=1, DATA=8'hFF.
//     -> SDO=1, ready=0, busy=0, done=0 throughout.
//  2. Single frame: CLKS_PER_BIT=1, DATA=8'hA5.
//     -> SDO sequence 0,1,0,1,0,0,1,0,1,1, then idle 1.
//     -> done high exactly once, 10 cycles after accept; ready low for 10 cycles.
//  3. Slow bits: CLKS_PER_BIT=4, DATA=8'h01.
//     -> SDO 0 for 4 cycles, 1 for 4, 0 for 28, then stop 1 for 4.
//     -> busy high for 40 cycles.
//  4. Back-to-back: valid held 1, DATA=8'h0F then 8'hF0 (CLKS_PER_BIT=1).
//     -> second start bit 11 cycles after first accept; both frames bit-exact.
//  5. Ignore while busy: change DATA to 8'h00 and pulse valid mid-frame of 8'h3C.
//     -> transmitted bits still match 8'h3C; no extra frame follows.
//  6. Reset mid-frame: assert n_Reset=0 during data bit 3.
//     -> next edge SDO=1, busy=0, no done.
//     -> after release, ready=1 and a new frame of 8'h55 sends correctly.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter (start 0, data LSB-first, stop 1)
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             CLK,
    input  logic             n_Reset,
    input  logic [WIDTH-1:0] DATA,
    input  logic             valid,
    output logic             ready,
    output logic             SDO,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [BW-1:0]    idx;
    logic [DW-1:0]    div;

    assign sr_nx = sr >> 1;

    // frame sequencer: divider counts down each bit period, reloading on every bit boundary
    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            state <= S_IDLE;
            SDO   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b0;
            sr    <= '0;
            idx   <= '0;
            div   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (valid && ready) begin
                        sr    <= DATA;
                        SDO   <= 1'b0;
                        state <= S_START;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= '0;
                        div   <= DIV_MAX;
                    end else begin
                        ready <= 1'b1;
                        SDO   <= 1'b1;
                    end
                S_START:
                    if (div != '0) begin
                        div <= div - DW'(1);
                    end else begin
                        SDO   <= sr[0];
                        state <= S_DATA;
                        div   <= DIV_MAX;
                    end
                S_DATA:
                    if (div != '0) begin
                        div <= div - DW'(1);
                    end else if (idx == LAST) begin
                        SDO   <= 1'b1;
                        state <= S_STOP;
                        div   <= DIV_MAX;
                    end else begin
                        sr  <= sr_nx;
                        SDO <= sr_nx[0];
                        idx <= idx + BW'(1);
                        div <= DIV_MAX;
                    end
                S_STOP:
                    if (div != '0) begin
                        div <= div - DW'(1);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
